// File: rtl/lc3_mem_ctrl_if.sv
// Memory-bus bundle between the LC-3 datapath/RAM and the bus initiator.
// The master modport is the controller side; the slave modport is datapath plus RAM.
interface lc3_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        R_W;
    logic        MEM_EN;
    logic [15:0] mem_dout;
    logic        R;

    modport master (
        input  req, we, addr, wdata, mem_dout, R,
        output busy, done, err, rdata, MAR, MDR, R_W, MEM_EN
    );

    modport slave (
        output req, we, addr, wdata, mem_dout, R,
        input  busy, done, err, rdata, MAR, MDR, R_W, MEM_EN
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-bus initiator: single-word read/write with ready handshake,
// read-data capture, timeout abort and a recovery state that waits out stale R.
//
// state   | meaning
// IDLE    | waiting for req; R is ignored here
// ISSUE   | MEM_EN high on the bus for this one cycle
// WAIT    | waiting for R, counting R=0 samples toward TIMEOUT
// RECOVER | transaction finished; hold busy until R returns low
module lc3_mem_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    lc3_mem_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;

    // Terminal count: the TIMEOUT-th consecutive R=0 sample sees cnt_q == TIMEOUT-1.
    localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        r_w_q, r_w_d;
    logic        mem_en_q, mem_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            rdata_q  <= '0;
            r_w_q    <= 1'b0;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            rdata_q  <= rdata_d;
            r_w_q    <= r_w_d;
            mem_en_q <= mem_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        rdata_d  = rdata_q;
        r_w_d    = r_w_q;
        busy_d   = busy_q;
        mem_en_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    mar_d    = bus.addr;
                    if (bus.we) begin
                        mdr_d = bus.wdata;
                    end
                    r_w_d    = bus.we;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.R) begin
                    if (!r_w_q) begin
                        rdata_d = bus.mem_dout;
                    end
                    done_d  = 1'b1;
                    state_d = RECOVER;
                end else begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cnt_q >= CNT_TC) begin
                        err_d   = 1'b1;
                        state_d = RECOVER;
                    end
                end
            end
            RECOVER: begin
                // A still-high R belongs to the finished transaction; never act on it.
                if (!bus.R) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign bus.MAR    = mar_q;
    assign bus.MDR    = mdr_q;
    assign bus.R_W    = r_w_q;
    assign bus.MEM_EN = mem_en_q;
endmodule
